// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: EX-stage ALU select decode plus radix-2 mult/div sequencer owning HI/LO.
// Latency: decode and stall are combinational; mult/div accepted in cycle 0, HI/LO and md_done in cycle WIDTH+2.
// Backpressure: stall holds IF/ID/EX while a HI/LO user meets a busy sequencer; the stalled op is re-presented.
//
// Ports: clk/rst_n (async active-low), valid_in/alu_op/funct/src_a/src_b from EX,
//        alu_ctl (4-bit ALU select), stall, busy, md_done, hi, lo.
// Optional: define MD_CANCEL_EN to add md_cancel, which flushes an in-flight mult/div without writing HI/LO.
`timescale 1ns/1ps
module alu_muldiv_ctrl #(
   parameter int WIDTH   = 32,
   parameter int ALUOP_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   input  logic [ALUOP_W-1:0] alu_op,
   input  logic [5:0]         funct,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
`ifdef MD_CANCEL_EN
   input  logic               md_cancel,
`endif
   output logic [3:0]         alu_ctl,
   output logic               stall,
   output logic               busy,
   output logic               md_done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MTHI = 6'b010001;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTLO = 6'b010011;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] p_hi;     // product high half / partial remainder
   logic [WIDTH-1:0] p_lo;     // multiplier bits / dividend bits shifting into quotient
   logic [WIDTH-1:0] op_b;     // multiplicand / divisor magnitude
   logic [WIDTH-1:0] raw_a;    // original dividend, returned in HI on divide by zero
   logic             is_div;
   logic             neg_q;    // negate product or quotient
   logic             neg_r;    // negate remainder (follows dividend sign)
   logic             div0;

   logic             cancel;
`ifdef MD_CANCEL_EN
   assign cancel = md_cancel;
`else
   assign cancel = 1'b0;
`endif

   // ---------------- instruction classification ----------------
   logic rtype, md_op, hilo_op, mthi_op, mtlo_op;
   always_comb begin
      rtype   = valid_in && (alu_op == ALUOP_W'(2));
      md_op   = rtype && (funct[5:2] == 4'b0110);    // 0110xx: mult/multu/div/divu
      hilo_op = md_op || (rtype && (funct[5:2] == 4'b0100)); // 0100xx: mfhi/mthi/mflo/mtlo
      mthi_op = rtype && (funct == F_MTHI);
      mtlo_op = rtype && (funct == F_MTLO);
   end

   assign busy  = (state != S_IDLE);
   assign stall = hilo_op && busy;

   // ---------------- ALU select decode ----------------
   always_comb begin
      alu_ctl = 4'b0010;
      case (alu_op)
         ALUOP_W'(0): alu_ctl = 4'b0010;
         ALUOP_W'(1): alu_ctl = 4'b0110;
         ALUOP_W'(3): alu_ctl = 4'b0000;
         ALUOP_W'(4): alu_ctl = 4'b0001;
         ALUOP_W'(5): alu_ctl = 4'b0111;
         ALUOP_W'(2): begin
            case (funct)
               F_ADD:   alu_ctl = 4'b0010;
               F_SUB:   alu_ctl = 4'b0110;
               F_AND:   alu_ctl = 4'b0000;
               F_OR:    alu_ctl = 4'b0001;
               F_SLT:   alu_ctl = 4'b0111;
               F_MFHI:  alu_ctl = 4'b1000;
               F_MFLO:  alu_ctl = 4'b1001;
               default: alu_ctl = 4'b0000;
            endcase
         end
         default: alu_ctl = 4'b0010;
      endcase
   end

   // ---------------- operand magnitudes at accept ----------------
   // funct[0]=0 selects the signed variants (mult, div); funct[1]=1 selects divide.
   logic             op_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   always_comb begin
      op_signed = ~funct[0];
      a_neg     = op_signed & src_a[WIDTH-1];
      b_neg     = op_signed & src_b[WIDTH-1];
      a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
      b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
   end

   // ---------------- one radix-2 step ----------------
   logic [WIDTH:0]   sum, shl;
   logic             ge;
   logic [WIDTH-1:0] step_hi, step_lo;
   always_comb begin
      // shift-add multiply: add multiplicand when LSB set, then shift {carry,hi,lo} right
      sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
      // restoring divide: shift next dividend bit into remainder, subtract if it fits
      shl = {p_hi, p_lo[WIDTH-1]};
      ge  = (shl >= {1'b0, op_b});
      if (is_div) begin
         // when ge, the true difference is below op_b so the low WIDTH bits are exact
         step_hi = ge ? (shl[WIDTH-1:0] - op_b) : shl[WIDTH-1:0];
         step_lo = {p_lo[WIDTH-2:0], ge};
      end else begin
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], p_lo[WIDTH-1:1]};
      end
   end

   // ---------------- sign correction ----------------
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   always_comb begin
      prod     = {p_hi, p_lo};
      prod_fix = neg_q ? (~prod + 1'b1) : prod;
      if (!is_div) begin
         {fix_hi, fix_lo} = prod_fix;
      end else if (div0) begin
         fix_hi = raw_a;
         fix_lo = {WIDTH{1'b1}};
      end else begin
         // min / -1 needs no special case: |min| stays min and the quotient wraps back to min
         fix_lo = neg_q ? (~p_lo + 1'b1) : p_lo;
         fix_hi = neg_r ? (~p_hi + 1'b1) : p_hi;
      end
   end

   // ---------------- sequencer ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         p_hi    <= '0;
         p_lo    <= '0;
         op_b    <= '0;
         raw_a   <= '0;
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
         md_done <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         md_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (md_op) begin
                  state  <= S_RUN;
                  cnt    <= CW'(WIDTH-1);
                  p_hi   <= '0;
                  p_lo   <= a_mag;
                  op_b   <= b_mag;
                  raw_a  <= src_a;
                  is_div <= funct[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  div0   <= funct[1] && (src_b == '0);
               end else if (mthi_op) begin
                  hi <= src_a;
               end else if (mtlo_op) begin
                  lo <= src_a;
               end
            end
            S_RUN: begin
               if (cancel) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  p_hi <= step_hi;
                  p_lo <= step_lo;
                  if (cnt == '0) state <= S_FIX;
                  else            cnt   <= cnt - 1'b1;
               end
            end
            S_FIX: begin
               state <= S_IDLE;
               if (!cancel) begin
                  hi      <= fix_hi;
                  lo      <= fix_lo;
                  md_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
`timescale 1ns/1ps
module tb_alu_muldiv_ctrl;

   localparam int W = 32;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         valid_in = 1'b0;
   logic [2:0]   alu_op = 3'd0;
   logic [5:0]   funct = 6'd0;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
`ifdef MD_CANCEL_EN
   logic         md_cancel = 1'b0;
`endif
   logic [3:0]   alu_ctl;
   logic         stall, busy, md_done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   alu_muldiv_ctrl #(.WIDTH(W), .ALUOP_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_in),
      .alu_op   (alu_op),
      .funct    (funct),
      .src_a    (src_a),
      .src_b    (src_b),
`ifdef MD_CANCEL_EN
      .md_cancel(md_cancel),
`endif
      .alu_ctl  (alu_ctl),
      .stall    (stall),
      .busy     (busy),
      .md_done  (md_done),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference models ----------------
   function automatic void md_model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] eh, output logic [W-1:0] el);
      int          sa, sb;
      longint      sp;
      logic [63:0] up;
      sa = int'(a);
      sb = int'(b);
      eh = '0;
      el = '0;
      case (f)
         F_MULT: begin
            sp = longint'(sa) * longint'(sb);
            {eh, el} = sp;
         end
         F_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            {eh, el} = up;
         end
         F_DIV: begin
            if (b == 0) begin
               el = '1; eh = a;
            end else if (sa == int'(32'h8000_0000) && sb == -1) begin
               el = 32'h8000_0000; eh = '0;
            end else begin
               el = sa / sb; eh = sa % sb;
            end
         end
         F_DIVU: begin
            if (b == 0) begin
               el = '1; eh = a;
            end else begin
               el = a / b; eh = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [3:0] dec_model(input logic [2:0] op, input logic [5:0] f);
      if (op == 3'd1) return 4'b0110;
      if (op == 3'd3) return 4'b0000;
      if (op == 3'd4) return 4'b0001;
      if (op == 3'd5) return 4'b0111;
      if (op != 3'd2) return 4'b0010;
      if (f == F_ADD)  return 4'b0010;
      if (f == F_SUB)  return 4'b0110;
      if (f == F_AND)  return 4'b0000;
      if (f == F_OR)   return 4'b0001;
      if (f == F_SLT)  return 4'b0111;
      if (f == F_MFHI) return 4'b1000;
      if (f == F_MFLO) return 4'b1001;
      return 4'b0000;
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_in = 1'b0; alu_op = 3'd0; funct = F_ADD;
   endtask

   // Presents an md op for one cycle, scrambles operands afterwards, and returns
   // the cycle index (accept = 0) at which md_done is seen, capped at 60.
   task automatic issue_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      valid_in = 1'b1; alu_op = 3'd2; funct = f; src_a = a; src_b = b;
      tick();
      idle_inputs();
      src_a = $urandom; src_b = $urandom;
      lat = 1;
      while (md_done !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   task automatic write_hilo(input logic [5:0] f, input logic [W-1:0] d);
      valid_in = 1'b1; alu_op = 3'd2; funct = f; src_a = d;
      tick();
      idle_inputs();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #12;
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_md_done: got %b expected 0", md_done); end
      checks++; if (hi !== '0)        begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== '0)        begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
      checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_op();
      write_hilo(F_MTHI, 32'h0000_0055);
      write_hilo(F_MTLO, 32'h0000_00AA);
      checks++; if (hi !== 32'h55) begin errors++; $display("FAIL rmid_pre_hi: got %h expected 00000055", hi); end
      valid_in = 1'b1; alu_op = 3'd2; funct = F_MULT; src_a = 32'h7FFF_FFFF; src_b = 32'd2;
      tick();
      idle_inputs();
      repeat (4) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_run: got %b expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      checks++; if (hi !== '0)        begin errors++; $display("FAIL rmid_hi: got %h expected 0", hi); end
      checks++; if (lo !== '0)        begin errors++; $display("FAIL rmid_lo: got %h expected 0", lo); end
      checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL rmid_md_done: got %b expected 0", md_done); end
      #3 rst_n = 1'b1;
      tick();
      for (int c = 0; c < 40; c++) begin
         checks++;
         if (md_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_after[%0d]: md_done=%b busy=%b expected 0 0", c, md_done, busy);
         end
         tick();
      end
      checks++; if ({hi, lo} !== '0) begin errors++; $display("FAIL rmid_final: got %h_%h expected 0", hi, lo); end
   endtask

   task automatic test_mult_latency();
      logic [W-1:0] eh, el;
      md_model(F_MULT, 32'hFFFF_FFFD, 32'd5, eh, el);
      valid_in = 1'b1; alu_op = 3'd2; funct = F_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mlat_accept_stall: got %b expected 0", stall); end
      tick();
      idle_inputs();
      for (int c = 1; c <= W + 1; c++) begin
         checks++;
         if (busy !== 1'b1 || md_done !== 1'b0) begin
            errors++; $display("FAIL mlat_cycle[%0d]: busy=%b md_done=%b expected 1 0", c, busy, md_done);
         end
         tick();
      end
      checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL mlat_done: got %b expected 1", md_done); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mlat_busy_end: got %b expected 0", busy); end
      checks++; if (hi !== eh)        begin errors++; $display("FAIL mlat_hi: got %h expected %h", hi, eh); end
      checks++; if (lo !== el)        begin errors++; $display("FAIL mlat_lo: got %h expected %h", lo, el); end
      tick();
      checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL mlat_pulse: got %b expected 0", md_done); end
   endtask

   task automatic test_mflo_stall();
      logic [W-1:0] a, b, eh, el;
      a = $urandom; b = $urandom;
      md_model(F_MULTU, a, b, eh, el);
      valid_in = 1'b1; alu_op = 3'd2; funct = F_MULTU; src_a = a; src_b = b;
      tick();
      idle_inputs();
      tick();
      // cycle 2: mthi while busy must be held off and never land
      valid_in = 1'b1; alu_op = 3'd2; funct = F_MTHI; src_a = 32'hDEAD_BEEF;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mflo_mthi_stall: got %b expected 1", stall); end
      tick();
      funct = F_MFLO;
      for (int c = 3; c <= W + 1; c++) begin
         src_a = $urandom; src_b = $urandom;
         #1;
         checks++;
         if (stall !== 1'b1 || alu_ctl !== 4'b1001) begin
            errors++; $display("FAIL mflo_wait[%0d]: stall=%b alu_ctl=%b expected 1 1001", c, stall, alu_ctl);
         end
         tick();
      end
      #1;
      checks++; if (stall !== 1'b0)      begin errors++; $display("FAIL mflo_release: got %b expected 0", stall); end
      checks++; if (alu_ctl !== 4'b1001) begin errors++; $display("FAIL mflo_ctl: got %b expected 1001", alu_ctl); end
      checks++; if (lo !== el)           begin errors++; $display("FAIL mflo_lo: got %h expected %h", lo, el); end
      checks++; if (hi !== eh)           begin errors++; $display("FAIL mflo_hi: got %h expected %h", hi, eh); end
      idle_inputs();
      tick();
   endtask

   task automatic test_div();
      logic [5:0]   fs [3] = '{F_DIV, F_DIVU, F_DIV};
      logic [W-1:0] as [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
      logic [W-1:0] bs [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
      logic [W-1:0] eh, el, a, b;
      logic [5:0]   f;
      int           lat;
      for (int i = 0; i < 3 + 16; i++) begin
         if (i < 3) begin
            f = fs[i]; a = as[i]; b = bs[i];
         end else begin
            f = ($urandom_range(0, 1) == 0) ? F_DIV : F_DIVU;
            a = $urandom;
            case ($urandom_range(0, 4))
               0: b = '0;
               1: b = 32'hFFFF_FFFF;
               2: b = $urandom_range(1, 15);
               3: b = -$urandom_range(1, 15);
               default: b = $urandom;
            endcase
         end
         md_model(f, a, b, eh, el);
         issue_md(f, a, b, lat);
         checks++; if (lat !== W + 2) begin errors++; $display("FAIL div_lat[%0d]: got %0d expected %0d", i, lat, W + 2); end
         checks++; if (lo !== el) begin errors++; $display("FAIL div_lo[%0d] %h/%h: got %h expected %h", i, a, b, lo, el); end
         checks++; if (hi !== eh) begin errors++; $display("FAIL div_hi[%0d] %h/%h: got %h expected %h", i, a, b, hi, eh); end
         tick();
      end
   endtask

   task automatic test_random_mult();
      logic [W-1:0] eh, el, a, b;
      logic [5:0]   f;
      int           lat;
      for (int i = 0; i < 12; i++) begin
         f = ($urandom_range(0, 1) == 0) ? F_MULT : F_MULTU;
         a = (i == 0) ? 32'h8000_0000 : $urandom;
         b = (i < 2) ? 32'h8000_0000 : (i == 2 ? 32'hFFFF_FFFF : $urandom);
         md_model(f, a, b, eh, el);
         issue_md(f, a, b, lat);
         checks++; if (lat !== W + 2) begin errors++; $display("FAIL mul_lat[%0d]: got %0d expected %0d", i, lat, W + 2); end
         checks++; if ({hi, lo} !== {eh, el}) begin
            errors++; $display("FAIL mul_res[%0d] f=%b %h*%h: got %h_%h expected %h_%h", i, f, a, b, hi, lo, eh, el);
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] eh, el, a, b;
      int           lat;
      a = $urandom; b = $urandom_range(1, 1000);
      issue_md(F_MULT, $urandom, $urandom, lat);
      checks++; if (lat !== W + 2) begin errors++; $display("FAIL b2b_first_lat: got %0d expected %0d", lat, W + 2); end
      // issued in the md_done cycle, the first cycle the sequencer is free again
      md_model(F_DIVU, a, b, eh, el);
      issue_md(F_DIVU, a, b, lat);
      checks++; if (lat !== W + 2) begin errors++; $display("FAIL b2b_second_lat: got %0d expected %0d", lat, W + 2); end
      checks++; if ({hi, lo} !== {eh, el}) begin
         errors++; $display("FAIL b2b_res: got %h_%h expected %h_%h", hi, lo, eh, el);
      end
      tick();
   endtask

   task automatic test_mthi_decode();
      logic [2:0]   ops  [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
      logic [3:0]   exps [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
      logic [5:0]   fl   [14] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                  F_MULT, F_MULTU, F_DIV, F_DIVU, 6'b100111};
      logic [W-1:0] d;
      valid_in = 1'b1; alu_op = 3'd2; funct = F_MTHI; src_a = 32'h0000_1234;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", stall); end
      tick();
      checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h expected 00001234", hi); end
      checks++; if (busy !== 1'b0 || md_done !== 1'b0) begin
         errors++; $display("FAIL mthi_side: busy=%b md_done=%b expected 0 0", busy, md_done);
      end
      funct = F_MFLO;
      #1;
      checks++; if (alu_ctl !== 4'b1001 || stall !== 1'b0) begin
         errors++; $display("FAIL mflo_idle: alu_ctl=%b stall=%b expected 1001 0", alu_ctl, stall);
      end
      funct = F_MFHI;
      #1;
      checks++; if (alu_ctl !== 4'b1000 || stall !== 1'b0) begin
         errors++; $display("FAIL mfhi_idle: alu_ctl=%b stall=%b expected 1000 0", alu_ctl, stall);
      end
      d = $urandom;
      funct = F_MTLO; src_a = d;
      tick();
      idle_inputs();
      checks++; if (lo !== d) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", lo, d); end
      checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", hi); end
      for (int i = 0; i < 5; i++) begin
         alu_op = ops[i]; funct = 6'(i);
         #1;
         checks++; if (alu_ctl !== exps[i]) begin
            errors++; $display("FAIL dec_op[%0d]: got %b expected %b", ops[i], alu_ctl, exps[i]);
         end
      end
      alu_op = 3'd2; funct = 6'b100111;
      #1;
      checks++; if (alu_ctl !== 4'b0000) begin errors++; $display("FAIL dec_nor: got %b expected 0000", alu_ctl); end
      for (int i = 0; i < 40; i++) begin
         alu_op = 3'($urandom_range(0, 7));
         funct  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 13)];
         #1;
         checks++; if (alu_ctl !== dec_model(alu_op, funct)) begin
            errors++; $display("FAIL dec_rand[%0d] op=%0d f=%b: got %b expected %b", i, alu_op, funct, alu_ctl,
                               dec_model(alu_op, funct));
         end
      end
      idle_inputs();
      tick();
   endtask

`ifdef MD_CANCEL_EN
   task automatic test_cancel();
      logic [W-1:0] eh, el;
      int           lat;
      write_hilo(F_MTHI, 32'hA5A5_0001);
      write_hilo(F_MTLO, 32'h5A5A_0002);
      valid_in = 1'b1; alu_op = 3'd2; funct = F_DIVU; src_a = 32'd100; src_b = 32'd3;
      tick();
      idle_inputs();
      repeat (9) tick();
      md_cancel = 1'b1;
      tick();
      md_cancel = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
      for (int c = 0; c < 40; c++) begin
         checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL cancel_done[%0d]: got 1 expected 0", c); end
         tick();
      end
      checks++; if (hi !== 32'hA5A5_0001 || lo !== 32'h5A5A_0002) begin
         errors++; $display("FAIL cancel_hilo: got %h_%h expected a5a50001_5a5a0002", hi, lo);
      end
      // cancel raised in the accept cycle itself is ignored
      valid_in = 1'b1; alu_op = 3'd2; funct = F_MULTU; src_a = 32'd6; src_b = 32'd7; md_cancel = 1'b1;
      tick();
      idle_inputs();
      md_cancel = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_idle_busy: got %b expected 1", busy); end
      lat = 1;
      while (md_done !== 1'b1 && lat < 60) begin tick(); lat++; end
      md_model(F_MULTU, 32'd6, 32'd7, eh, el);
      checks++; if (lat !== W + 2 || lo !== el || hi !== eh) begin
         errors++; $display("FAIL cancel_idle_res: lat=%0d got %h_%h expected lat %0d %h_%h", lat, hi, lo, W + 2, eh, el);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_op();
      test_mult_latency();
      test_mflo_stall();
      test_div();
      test_random_mult();
      test_back_to_back();
      test_mthi_decode();
`ifdef MD_CANCEL_EN
      test_cancel();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
